vx_ahb_mem_arbiter: RTL and testbench

//  Shares one VX_ahb_adapter (single outstanding txn, 16-beat AHB line) among NUM_REQS Vortex mem requesters.

---
 rtl/vx_ahb_arb_pkg.sv | 27 ++
 rtl/vx_rr_arbiter.sv | 57 +++++
 rtl/vx_ahb_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_vx_ahb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_ahb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : vx_ahb_arb_pkg
//  Brief   : Shared types and helpers for the AHB memory arbiter slice
//            (FSM state encoding, requester-index width helper).
//  Revision: 1.0  initial release
// ============================================================================
package vx_ahb_arb_pkg;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Requester index width; a single requester still needs one bit
    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int c_NUM_REQS_DEFAULT = 4;
    localparam int IDX_W = (c_NUM_REQS_DEFAULT > 1) ? $clog2(c_NUM_REQS_DEFAULT) : 1;

endpackage
`default_nettype wire

// File: rtl/vx_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : vx_rr_arbiter
//  Brief   : Combinational round-robin pick. Searches the valid vector
//            starting one past the stored pointer; the pointer register lives
//            here and is reloaded by the owner when a transaction retires.
//  Revision: 1.0  initial release
// ============================================================================
module vx_rr_arbiter
    import vx_ahb_arb_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int IDX_W    = arb_idx_w(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] i_valid,
    input  logic                i_ptr_load,
    input  logic [IDX_W-1:0]    i_ptr_val,
    output logic                o_grant_any,
    output logic [NUM_REQS-1:0] o_grant_onehot,
    output logic [IDX_W-1:0]    o_grant_idx
);

    // Pointer reset to the last requester so requester 0 wins first
    localparam logic [IDX_W-1:0] c_PTR_RST = IDX_W'(NUM_REQS - 1);

    logic [IDX_W-1:0] r_ptr;
    int               w_pos;

    // Pointer holds the index of the most recently served requester
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= c_PTR_RST;
        end else if (i_ptr_load) begin
            r_ptr <= i_ptr_val;
        end
    end

    // First valid requester found walking forward from ptr+1 (wrapping)
    always_comb begin
        o_grant_any    = 1'b0;
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        w_pos          = 0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            w_pos = (int'(r_ptr) + k) % NUM_REQS;
            if (!o_grant_any && i_valid[w_pos]) begin
                o_grant_any           = 1'b1;
                o_grant_onehot[w_pos] = 1'b1;
                o_grant_idx           = IDX_W'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vx_ahb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : vx_ahb_mem_arbiter
//  Brief   : Shares a single-outstanding AHB adapter among NUM_REQS memory
//            requesters. Round-robin grant, latches the winner, drives the
//            adapter, returns response data plus the original tag to the owner.
//  Options : VX_AHB_ARB_WDOG_EN - enables the transaction watchdog
//            (WDOG_CYCLES); without it wdog_err is tied low.
//  Revision: 1.0  initial release
// ============================================================================
module vx_ahb_mem_arbiter
    import vx_ahb_arb_pkg::*;
#(
    parameter int NUM_REQS      = 4,
    parameter int VX_DATA_WIDTH = 512,
    parameter int VX_ADDR_WIDTH = 26,
    parameter int VX_TAG_WIDTH  = 8,
    parameter int WDOG_CYCLES   = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               in_req_valid,
    input  logic [NUM_REQS-1:0]               in_req_rw,
    input  logic [NUM_REQS*VX_ADDR_WIDTH-1:0] in_req_addr,
    input  logic [NUM_REQS*VX_DATA_WIDTH-1:0] in_req_data,
    input  logic [NUM_REQS*VX_TAG_WIDTH-1:0]  in_req_tag,
    output logic [NUM_REQS-1:0]               in_req_ready,
    output logic [NUM_REQS-1:0]               in_rsp_valid,
    output logic [VX_DATA_WIDTH-1:0]          in_rsp_data,
    output logic [VX_TAG_WIDTH-1:0]           in_rsp_tag,
    input  logic [NUM_REQS-1:0]               in_rsp_ready,
    output logic                              out_req_valid,
    output logic                              out_req_rw,
    output logic [VX_ADDR_WIDTH-1:0]          out_req_addr,
    output logic [VX_DATA_WIDTH-1:0]          out_req_data,
    input  logic                              out_req_ready,
    input  logic                              out_rsp_valid,
    input  logic [VX_DATA_WIDTH-1:0]          out_rsp_data,
    output logic                              out_rsp_ready,
    output logic                              busy,
    output logic                              wdog_err
);

    localparam int c_IDX_W = arb_idx_w(NUM_REQS);

    arb_state_e               r_state;
    arb_state_e               w_state_nxt;

    logic                     w_grant_any;
    logic [NUM_REQS-1:0]      w_grant_onehot;
    logic [c_IDX_W-1:0]       w_grant_idx;

    logic                     w_accept;
    logic                     w_rsp_done;
    logic                     w_wdog_expire;
    logic                     w_ptr_load;

    logic                     r_rw;
    logic [VX_ADDR_WIDTH-1:0] r_addr;
    logic [VX_DATA_WIDTH-1:0] r_data;
    logic [VX_TAG_WIDTH-1:0]  r_tag;
    logic [c_IDX_W-1:0]       r_idx;
    logic [VX_DATA_WIDTH-1:0] r_rsp_data;

    // Accept is blocked while reset is asserted so every output reads zero
    assign w_accept   = (r_state == IDLE) && reset && w_grant_any;
    assign w_rsp_done = (r_state == RESP) && in_rsp_ready[r_idx];
    // Pointer advances to the owner whenever its transaction retires or is dropped
    assign w_ptr_load = w_rsp_done || w_wdog_expire;

    vx_rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .IDX_W    (c_IDX_W)
    ) u_rr_arbiter (
        .clk            (clk),
        .reset          (reset),
        .i_valid        (in_req_valid),
        .i_ptr_load     (w_ptr_load),
        .i_ptr_val      (r_idx),
        .o_grant_any    (w_grant_any),
        .o_grant_onehot (w_grant_onehot),
        .o_grant_idx    (w_grant_idx)
    );

`ifdef VX_AHB_ARB_WDOG_EN
    localparam int c_WDOG_W = $clog2(WDOG_CYCLES) + 1;

    logic [c_WDOG_W-1:0] r_wdog_cnt;

    // Watchdog restarts on each issue and counts while the adapter owns the txn
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog_cnt <= '0;
        end else if (w_accept) begin
            r_wdog_cnt <= '0;
        end else if ((r_state == ISSUE) || (r_state == WAIT)) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    assign w_wdog_expire = ((r_state == ISSUE) || (r_state == WAIT)) &&
                           (r_wdog_cnt == c_WDOG_W'(WDOG_CYCLES - 1));
`else
    assign w_wdog_expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: watchdog expiry pre-empts any adapter handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (w_wdog_expire)      w_state_nxt = IDLE;
                else if (out_req_ready) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_wdog_expire)      w_state_nxt = IDLE;
                else if (out_rsp_valid) w_state_nxt = RESP;
            end
            RESP: begin
                if (w_rsp_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; fields are zero whenever they are not meaningful
    always_comb begin
        in_req_ready  = '0;
        in_rsp_valid  = '0;
        in_rsp_data   = '0;
        in_rsp_tag    = '0;
        out_req_valid = 1'b0;
        out_req_rw    = 1'b0;
        out_req_addr  = '0;
        out_req_data  = '0;
        out_rsp_ready = 1'b0;
        busy          = (r_state != IDLE);
        wdog_err      = w_wdog_expire;
        case (r_state)
            IDLE: begin
                if (w_accept) in_req_ready = w_grant_onehot;
            end
            ISSUE: begin
                out_req_valid = !w_wdog_expire;
                out_req_rw    = r_rw;
                out_req_addr  = r_addr;
                out_req_data  = r_data;
            end
            WAIT: begin
                out_rsp_ready = !w_wdog_expire;
            end
            RESP: begin
                in_rsp_valid = NUM_REQS'(1) << r_idx;
                in_rsp_data  = r_rsp_data;
                in_rsp_tag   = r_tag;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Capture the winning request on accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rw   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_tag  <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_rw   <= in_req_rw[w_grant_idx];
            r_addr <= in_req_addr[w_grant_idx*VX_ADDR_WIDTH +: VX_ADDR_WIDTH];
            r_data <= in_req_data[w_grant_idx*VX_DATA_WIDTH +: VX_DATA_WIDTH];
            r_tag  <= in_req_tag[w_grant_idx*VX_TAG_WIDTH +: VX_TAG_WIDTH];
            r_idx  <= w_grant_idx;
        end
    end

    // Buffer the adapter response so the adapter is freed immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_data <= '0;
        end else if ((r_state == WAIT) && out_rsp_valid && !w_wdog_expire) begin
            r_rsp_data <= out_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_ahb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_vx_ahb_mem_arbiter
//  Brief   : Randomized bench for vx_ahb_mem_arbiter with a transaction-level
//            reference (round-robin rule, line memory, adapter model).
//            Watchdog scenarios are exercised when VX_AHB_ARB_WDOG_EN is set.
//  Revision: 1.0  initial release
// ============================================================================
module tb_vx_ahb_mem_arbiter;

    localparam int NR = 4;
    localparam int DW = 512;
    localparam int AW = 26;
    localparam int TW = 8;
    localparam int WD = 16;
    localparam int NCYC = 3000;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     in_req_valid, in_req_rw, in_req_ready, in_rsp_valid, in_rsp_ready;
    logic [NR*AW-1:0]  in_req_addr;
    logic [NR*DW-1:0]  in_req_data;
    logic [NR*TW-1:0]  in_req_tag;
    logic [DW-1:0]     in_rsp_data;
    logic [TW-1:0]     in_rsp_tag;
    logic              out_req_valid, out_req_rw, out_req_ready;
    logic [AW-1:0]     out_req_addr;
    logic [DW-1:0]     out_req_data;
    logic              out_rsp_valid, out_rsp_ready;
    logic [DW-1:0]     out_rsp_data;
    logic              busy, wdog_err;

    always #5 clk = ~clk;

    vx_ahb_mem_arbiter #(
        .NUM_REQS(NR), .VX_DATA_WIDTH(DW), .VX_ADDR_WIDTH(AW),
        .VX_TAG_WIDTH(TW), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
        .in_req_data(in_req_data), .in_req_tag(in_req_tag), .in_req_ready(in_req_ready),
        .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
        .in_rsp_ready(in_rsp_ready),
        .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
        .out_req_data(out_req_data), .out_req_ready(out_req_ready),
        .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_ready(out_rsp_ready),
        .busy(busy), .wdog_err(wdog_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    typedef enum int {M_IDLE, M_ISS, M_WAIT, M_RESP} phase_t;
    phase_t        ph;
    int            last_served;
    int            cur;
    logic          cur_rw;
    int            cur_addr;
    logic [DW-1:0] cur_data;
    logic [TW-1:0] cur_tag;
    logic [DW-1:0] exp_rsp;
    int            wd_cnt;
    int            done_cnt;
    int            wdog_cnt_seen;
    logic [DW-1:0] mem [16];

    // requester-side stimulus
    logic          req_rw   [NR];
    int            req_addr [NR];
    logic [DW-1:0] req_data [NR];
    logic [TW-1:0] req_tag  [NR];
    logic [NR-1:0] acc_vec;

    // adapter model
    bit            adp_act, adp_dead, rsp_taken;
    int            adp_cnt;
    logic [DW-1:0] adp_data;

    // reset-in-flight scenario
    bit            rst_done;
    int            rst_cnt;

    function automatic logic [DW-1:0] rnd_line();
        logic [DW-1:0] v;
        for (int w = 0; w < DW/32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Round-robin rule: first valid requester after the last one served
    function automatic int rr_pick(input logic [NR-1:0] v, input int after);
        for (int k = 1; k <= NR; k++)
            if (v[(after + k) % NR]) return (after + k) % NR;
        return -1;
    endfunction

    task automatic new_req(input int i);
        req_rw[i]   = 1'($urandom_range(0, 1));
        req_addr[i] = $urandom_range(0, 15);
        req_data[i] = rnd_line();
        req_tag[i]  = TW'($urandom_range(0, 255));
    endtask

    task automatic pack();
        for (int i = 0; i < NR; i++) begin
            in_req_rw[i]             = req_rw[i];
            in_req_addr[i*AW +: AW]  = AW'(req_addr[i]);
            in_req_data[i*DW +: DW]  = req_data[i];
            in_req_tag[i*TW +: TW]   = req_tag[i];
        end
    endtask

    task automatic model_reset();
        ph          = M_IDLE;
        last_served = NR - 1;
        wd_cnt      = 0;
        adp_act     = 0;
        adp_dead    = 0;
        rsp_taken   = 0;
        acc_vec     = '0;
    endtask

    // Sample DUT at the falling edge and advance the reference model
    task automatic observe();
        bit            exp_wd;
        int            pick;
        logic [NR-1:0] exp_ready;
        acc_vec = '0;
        if (!reset) begin
            check("rst_ctl", DW'({in_req_ready, in_rsp_valid, in_rsp_tag, out_req_valid, out_req_rw,
                                  out_req_addr, out_rsp_ready, busy, wdog_err}), '0);
            check("rst_data", in_rsp_data | out_req_data, '0);
            return;
        end
        exp_wd = 1'b0;
        if (ph == M_ISS || ph == M_WAIT) begin
            wd_cnt++;
`ifdef VX_AHB_ARB_WDOG_EN
            exp_wd = (wd_cnt == WD);
`endif
        end
        check("busy", DW'(busy), DW'(ph != M_IDLE));
        check("wdog_err", DW'(wdog_err), DW'(exp_wd));
        check("out_req_valid", DW'(out_req_valid), DW'(ph == M_ISS && !exp_wd));
        check("out_rsp_ready", DW'(out_rsp_ready), DW'(ph == M_WAIT && !exp_wd));
        if (ph != M_RESP) begin
            check("rsp_valid_idle", DW'(in_rsp_valid), '0);
            check("rsp_data_idle", in_rsp_data | DW'(in_rsp_tag), '0);
        end

        if (exp_wd) begin
            wdog_cnt_seen++;
            ph          = M_IDLE;
            last_served = cur;
            adp_act     = 0;
            rsp_taken   = 1;
            return;
        end

        case (ph)
            M_IDLE: begin
                pick      = rr_pick(in_req_valid, last_served);
                exp_ready = (pick >= 0) ? NR'(1) << pick : '0;
                check("grant", DW'(in_req_ready), DW'(exp_ready));
                if (pick >= 0) begin
                    acc_vec  = exp_ready;
                    cur      = pick;
                    cur_rw   = req_rw[pick];
                    cur_addr = req_addr[pick];
                    cur_data = req_data[pick];
                    cur_tag  = req_tag[pick];
                    wd_cnt   = 0;
                    ph       = M_ISS;
                end
            end
            M_ISS: begin
                check("no_accept", DW'(in_req_ready), '0);
                check("out_rw", DW'(out_req_rw), DW'(cur_rw));
                check("out_addr", DW'(out_req_addr), DW'(cur_addr));
                check("out_data", out_req_data, cur_data);
                if (out_req_ready) begin
                    adp_act  = 1;
                    adp_cnt  = $urandom_range(0, 3);
                    adp_data = cur_rw ? cur_data : mem[cur_addr];
                    if (cur_rw) mem[cur_addr] = cur_data;
                    adp_dead = 0;
`ifdef VX_AHB_ARB_WDOG_EN
                    adp_dead = ($urandom_range(0, 5) == 0);
`endif
                    ph = M_WAIT;
                end
            end
            M_WAIT: begin
                check("no_accept", DW'(in_req_ready), '0);
                if (out_rsp_valid) begin
                    exp_rsp   = out_rsp_data;
                    adp_act   = 0;
                    rsp_taken = 1;
                    ph        = M_RESP;
                end
            end
            M_RESP: begin
                check("no_accept", DW'(in_req_ready), '0);
                check("rsp_valid", DW'(in_rsp_valid), DW'(NR'(1) << cur));
                check("rsp_tag", DW'(in_rsp_tag), DW'(cur_tag));
                check("rsp_data", in_rsp_data, exp_rsp);
                if (in_rsp_ready[cur]) begin
                    done_cnt++;
                    last_served = cur;
                    ph          = M_IDLE;
                end
            end
            default: ph = M_IDLE;
        endcase
    endtask

    // Drive the next cycle's inputs shortly after the rising edge
    task automatic drive(input int cyc);
        if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 0) reset = 1'b1;
            return;
        end
        if (!rst_done && cyc > 200 && ph == M_WAIT) begin
            rst_done      = 1;
            rst_cnt       = 2;
            reset         = 1'b0;
            model_reset();
            out_rsp_valid = 1'b0;
            out_rsp_data  = '0;
            for (int i = 0; i < NR; i++) new_req(i);
            in_req_valid  = '1;
            pack();
            return;
        end
        // requesters
        for (int i = 0; i < NR; i++) begin
            if (acc_vec[i]) begin
                in_req_valid[i] = 1'($urandom_range(0, 1));
                new_req(i);
            end else if (in_req_valid[i]) begin
                if ($urandom_range(0, 7) == 0) in_req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                in_req_valid[i] = 1'b1;
                new_req(i);
            end
            in_rsp_ready[i] = ($urandom_range(0, 9) < 7);
        end
        pack();
        // adapter
        out_req_ready = ($urandom_range(0, 3) != 0);
        if (rsp_taken) begin
            rsp_taken     = 0;
            out_rsp_valid = 1'b0;
            out_rsp_data  = '0;
        end
        if (adp_act && !adp_dead && !out_rsp_valid) begin
            if (adp_cnt == 0) begin
                out_rsp_valid = 1'b1;
                out_rsp_data  = adp_data;
            end else begin
                adp_cnt--;
            end
        end
    endtask

    initial begin
        reset         = 1'b0;
        in_req_valid  = '0;
        in_rsp_ready  = '0;
        out_req_ready = 1'b0;
        out_rsp_valid = 1'b0;
        out_rsp_data  = '0;
        done_cnt      = 0;
        wdog_cnt_seen = 0;
        rst_done      = 0;
        rst_cnt       = 0;
        cur           = 0;
        for (int m = 0; m < 16; m++) mem[m] = rnd_line();
        mem[4] = {64{8'hA5}};
        for (int i = 0; i < NR; i++) new_req(i);
        pack();
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        observe();

        // first transaction: requester 0 reads line 0x4 with tag 0x5A
        @(posedge clk);
        #1;
        req_rw[0]     = 1'b0;
        req_addr[0]   = 4;
        req_tag[0]    = 8'h5A;
        in_req_valid  = 4'b0001;
        in_rsp_ready  = '1;
        out_req_ready = 1'b1;
        pack();
        reset = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            observe();
            @(posedge clk);
            #1;
            drive(cyc);
        end

        check("progress", DW'(done_cnt > 100), DW'(1));
        check("reset_scenario", DW'(rst_done), DW'(1));
`ifdef VX_AHB_ARB_WDOG_EN
        check("wdog_seen", DW'(wdog_cnt_seen > 0), DW'(1));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
